turfbus_data_tx: RTL

- Transmit side of the TURFbus data path: sends framed event/readout words from the SURF to the TURF over the 8-bit TD lanes.
- Uses an SREQ/TREQ request–grant handshake; the top level drives SREQ_neg and receives TREQ_neg, inverting both.
- Pulls 32-bit words from a first-word-fall-through FIFO upstream (LAB4 readout buffer).
- Runs entirely in the wbc_clk domain; the TD OBUFDS are driven from td_o.

---
 rtl/turfbus_data_tx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/turfbus_data_tx.sv
// TURFbus TD-lane transmitter: requests the bus, then sends sync, length, data words
// (LSB first) and a checksum, pulling words from an upstream FWFT FIFO.
module turfbus_data_tx #(
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned GRANT_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        underrun_o,
    input  logic [31:0] dat_i,
    input  logic        dat_valid_i,
    output logic        dat_rd_o,
    output logic        sreq_o,
    input  logic        treq_i,
    output logic [7:0]  td_o
);

    localparam int unsigned TMO_W = $clog2(GRANT_TIMEOUT);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE, REQ, HDR_SYNC, HDR_LEN, DATA, CKSUM, REL
    } state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   len_q, len_d;
    logic [BYTE_W-1:0]   rem_q, rem_d;
    logic [1:0]          idx_q, idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [BYTE_W-1:0]   sum_q, sum_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [BYTE_W-1:0]   td_q, td_d;
    logic                rd_q, rd_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                sreq_q, sreq_d;
    logic                busy_q, busy_d;
    logic [WORD_W-1:0]   fetch_c;

    // An empty FIFO on a read strobe substitutes a zero word.
    assign fetch_c = dat_valid_i ? dat_i : '0;

    // Registers hold what is on the lane now; next values follow the next state.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        word_d  = word_q;
        sum_d   = sum_q;
        tmo_d   = tmo_q;
        td_d    = '0;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = REQ;
                    len_d   = len_i;
                    tmo_d   = '0;
                end
            end
            REQ: begin
                if (treq_i) begin
                    state_d = HDR_SYNC;
                    td_d    = SYNC_BYTE;
                    sum_d   = '0;
                end else if (tmo_q == TMO_W'(GRANT_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HDR_SYNC: begin
                state_d = HDR_LEN;
                td_d    = len_q - 8'd1;
                sum_d   = len_q - 8'd1;
                rd_d    = 1'b1;
            end
            HDR_LEN: begin
                state_d = DATA;
                word_d  = fetch_c;
                idx_d   = 2'd0;
                rem_d   = len_q;
                td_d    = fetch_c[7:0];
                sum_d   = sum_q + fetch_c[7:0];
            end
            DATA: begin
                if (idx_q == 2'd3) begin
                    if (rem_q == 8'd1) begin
                        state_d = CKSUM;
                        td_d    = sum_q;
                    end else begin
                        word_d = fetch_c;
                        rem_d  = rem_q - 8'd1;
                        idx_d  = 2'd0;
                        td_d   = fetch_c[7:0];
                        sum_d  = sum_q + fetch_c[7:0];
                    end
                end else begin
                    idx_d = 2'(idx_q + 2'd1);
                    td_d  = word_q[{idx_d, 3'b000} +: BYTE_W];
                    sum_d = sum_q + td_d;
                    // Strobe lands on byte 3 so the next word is ready for the following byte.
                    rd_d  = (idx_q == 2'd2) && (rem_q != 8'd1);
                end
            end
            CKSUM: begin
                state_d = REL;
                done_d  = 1'b1;
            end
            REL: begin
                if (!treq_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sreq_d = (state_d == REQ) || (state_d == HDR_SYNC) || (state_d == HDR_LEN) ||
                 (state_d == DATA) || (state_d == CKSUM);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
            td_q    <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sreq_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            td_q    <= td_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sreq_q  <= sreq_d;
            busy_q  <= busy_d;
        end
    end

    assign td_o       = td_q;
    assign dat_rd_o   = rd_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign sreq_o     = sreq_q;
    assign busy_o     = busy_q;
    assign underrun_o = rd_q & ~dat_valid_i;

endmodule
